// File: rtl/led_pattern_sequencer_pkg.sv
// Shared constants for the LED pattern sequencer: pattern indices, FSM
// state encoding, the blank display value and a wrapping index increment.
package led_pat_pkg;

  // Pattern indices, as seen on pattern_id and sel_id
  localparam logic [2:0] PAT_DOT_L2R  = 3'd0;
  localparam logic [2:0] PAT_DOT_R2L  = 3'd1;
  localparam logic [2:0] PAT_FILL_L2R = 3'd2;
  localparam logic [2:0] PAT_FILL_R2L = 3'd3;
  localparam logic [2:0] PAT_DOT_I2O  = 3'd4;
  localparam logic [2:0] PAT_DOT_O2I  = 3'd5;
  localparam logic [2:0] PAT_FILL_I2O = 3'd6;
  localparam logic [2:0] PAT_FILL_O2I = 3'd7;

  // Sequencer FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  // All LEDs off; also the terminal step of every frame
  localparam logic [7:0] BLANK = 8'h00;

  typedef logic [7:0] led_t;

  // Next pattern index; 7 wraps to 0 through the natural 3-bit overflow
  function automatic logic [2:0] pat_inc(input logic [2:0] id);
    return id + 3'd1;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between the board buttons/switches and the sequencer.
// The sequencer takes the slave side; whoever drives the buttons takes master.
interface led_pattern_sequencer_if;
  logic       run;
  logic       stop;
  logic       next_btn;
  logic       sel_we;
  logic [2:0] sel_id;
  logic       auto_en;
  logic [7:0] led;
  logic [2:0] pattern_id;
  logic       running;
  logic       frame_done;

  modport master (
    output run, stop, next_btn, sel_we, sel_id, auto_en,
    input  led, pattern_id, running, frame_done
  );

  modport slave (
    input  run, stop, next_btn, sel_we, sel_id, auto_en,
    output led, pattern_id, running, frame_done
  );
endinterface

// File: rtl/led_pattern_step.sv
// Per-pattern rules: first value of a frame and the successor of the current
// display. A blank display always continues with the first value, and every
// lit sequence ends in a blank, so the frame boundary is simply led==BLANK.
module led_pattern_step
  import led_pat_pkg::*;
(
  input  logic [2:0] pattern_id,
  input  logic [7:0] cur,
  output logic [7:0] first,
  output logic [7:0] nxt
);

  // First value shown for each pattern
  always_comb begin
    first = BLANK;
    case (pattern_id)
      PAT_DOT_L2R, PAT_FILL_L2R: first = 8'h80;
      PAT_DOT_R2L, PAT_FILL_R2L: first = 8'h01;
      PAT_DOT_I2O, PAT_FILL_I2O: first = 8'h18;
      PAT_DOT_O2I, PAT_FILL_O2I: first = 8'h81;
      default:                   first = BLANK;
    endcase
  end

  // Successor value; fill patterns blank out once fully lit, centre patterns
  // use small lookup tables and blank out after their fourth value
  always_comb begin
    nxt = BLANK;
    if (cur == BLANK) begin
      nxt = first;
    end else begin
      case (pattern_id)
        PAT_DOT_L2R: nxt = {1'b0, cur[7:1]};
        PAT_DOT_R2L: nxt = {cur[6:0], 1'b0};
        PAT_FILL_L2R: begin
          if (cur == 8'hFF) nxt = BLANK;
          else              nxt = {1'b1, cur[7:1]};
        end
        PAT_FILL_R2L: begin
          if (cur == 8'hFF) nxt = BLANK;
          else              nxt = {cur[6:0], 1'b1};
        end
        PAT_DOT_I2O: begin
          case (cur)
            8'h18:   nxt = 8'h24;
            8'h24:   nxt = 8'h42;
            8'h42:   nxt = 8'h81;
            default: nxt = BLANK;
          endcase
        end
        PAT_DOT_O2I: begin
          case (cur)
            8'h81:   nxt = 8'h42;
            8'h42:   nxt = 8'h24;
            8'h24:   nxt = 8'h18;
            default: nxt = BLANK;
          endcase
        end
        PAT_FILL_I2O: begin
          case (cur)
            8'h18:   nxt = 8'h3C;
            8'h3C:   nxt = 8'h7E;
            8'h7E:   nxt = 8'hFF;
            default: nxt = BLANK;
          endcase
        end
        PAT_FILL_O2I: begin
          case (cur)
            8'h81:   nxt = 8'hC3;
            8'hC3:   nxt = 8'hE7;
            8'hE7:   nxt = 8'hFF;
            default: nxt = BLANK;
          endcase
        end
        default: nxt = BLANK;
      endcase
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: step-rate divider, IDLE/RUN/PAUSE control, frame
// repeat counting with auto-advance, manual next and direct pattern select.
// Same-cycle priority is stop > sel_we > next_btn > divider tick.
module led_pattern_sequencer
  import led_pat_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int REPEATS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  led_pattern_sequencer_if.slave  bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int REP_W = (REPEATS  > 1) ? $clog2(REPEATS)  : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEATS - 1);

  logic [1:0]       state_r,      state_nx_s;
  logic [DIV_W-1:0] div_r,        div_nx_s;
  logic [REP_W-1:0] rep_r,        rep_nx_s;
  logic [2:0]       pat_r,        pat_nx_s;
  led_t             led_r,        led_nx_s;
  logic             frame_done_r, frame_done_nx_s;

  logic             tick_s;
  logic             frame_end_s;
  logic             advance_s;
  logic [2:0]       target_id_s;
  led_t             first_s;
  led_t             nxt_s;

  // Tick/frame-end detection and the pattern whose rules apply this cycle
  always_comb begin
    tick_s      = (state_r == RUN) && bus.run && (div_r == DIV_LAST);
    frame_end_s = tick_s && (led_r == BLANK);
    advance_s   = frame_end_s && bus.auto_en && (rep_r == REP_LAST);
    if (bus.sel_we) begin
      target_id_s = bus.sel_id;
    end else if (bus.next_btn || advance_s) begin
      target_id_s = pat_inc(pat_r);
    end else begin
      target_id_s = pat_r;
    end
  end

  led_pattern_step u_step (
    .pattern_id (target_id_s),
    .cur        (led_r),
    .first      (first_s),
    .nxt        (nxt_s)
  );

  // Next-state logic applying the stop > select > next > tick priority
  always_comb begin
    state_nx_s      = state_r;
    div_nx_s        = div_r;
    rep_nx_s        = rep_r;
    pat_nx_s        = pat_r;
    led_nx_s        = led_r;
    frame_done_nx_s = 1'b0;
    if (bus.stop) begin
      state_nx_s = IDLE;
      led_nx_s   = BLANK;
      div_nx_s   = {DIV_W{1'b0}};
      rep_nx_s   = {REP_W{1'b0}};
    end else if (bus.sel_we || bus.next_btn) begin
      pat_nx_s = target_id_s;
      rep_nx_s = {REP_W{1'b0}};
      div_nx_s = {DIV_W{1'b0}};
      if (state_r == IDLE) begin
        led_nx_s = BLANK;
      end else begin
        led_nx_s = first_s;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.run) begin
            state_nx_s = RUN;
            led_nx_s   = first_s;
            div_nx_s   = {DIV_W{1'b0}};
          end else begin
            state_nx_s = IDLE;
          end
        end
        RUN: begin
          if (!bus.run) begin
            state_nx_s = PAUSE;
          end else if (tick_s) begin
            div_nx_s = {DIV_W{1'b0}};
            if (frame_end_s) begin
              frame_done_nx_s = 1'b1;
              led_nx_s        = first_s;
              if (!bus.auto_en) begin
                rep_nx_s = {REP_W{1'b0}};
              end else if (advance_s) begin
                pat_nx_s = target_id_s;
                rep_nx_s = {REP_W{1'b0}};
              end else begin
                rep_nx_s = rep_r + REP_W'(1);
              end
            end else begin
              led_nx_s = nxt_s;
            end
          end else begin
            div_nx_s = div_r + DIV_W'(1);
          end
        end
        PAUSE: begin
          if (bus.run) begin
            state_nx_s = RUN;
          end else begin
            state_nx_s = PAUSE;
          end
        end
        default: begin
          state_nx_s = IDLE;
          led_nx_s   = BLANK;
          div_nx_s   = {DIV_W{1'b0}};
          rep_nx_s   = {REP_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      div_r        <= {DIV_W{1'b0}};
      rep_r        <= {REP_W{1'b0}};
      pat_r        <= PAT_DOT_L2R;
      led_r        <= BLANK;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      div_r        <= div_nx_s;
      rep_r        <= rep_nx_s;
      pat_r        <= pat_nx_s;
      led_r        <= led_nx_s;
      frame_done_r <= frame_done_nx_s;
    end
  end

  assign bus.led        = led_r;
  assign bus.pattern_id = pat_r;
  assign bus.running    = (state_r == RUN);
  assign bus.frame_done = frame_done_r;

endmodule
